// File: rtl/param_seq_detector_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package param_seq_detector_pkg;

   localparam int unsigned MAX_PAT_W = 32;

   typedef enum logic {
      ST_UNLOADED = 1'b0,
      ST_HUNT     = 1'b1
   } state_t;

   // Low-ones mask of width MAX_PAT_W; callers truncate to their PAT_W.
   function automatic logic [MAX_PAT_W-1:0] mask(input int unsigned len);
      logic [MAX_PAT_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/param_seq_detector_cnt.sv
// Saturating match counter with synchronous clear (clear beats increment).
module seq_match_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/param_seq_detector.sv
// Mealy detector for a run-time programmable 1..PAT_W bit serial pattern,
// with overlap control, valid stall and saturating match count.
module param_seq_detector
   import param_seq_detector_pkg::*;
#(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             y,
   output logic             y_q,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed,
   output logic             load_err
);

   state_t           state;
   state_t           state_next;
   logic [PAT_W-1:0] pat_r;
   logic [LEN_W-1:0] len_r;
   logic [PAT_W-2:0] hist;
   logic [LEN_W-1:0] fill;

   logic             legal;
   logic             load_ok;
   logic             fill_ok;
   logic             hit;
   logic [PAT_W-1:0] cand;
   logic [PAT_W-1:0] pat_mask;

   assign armed = (state == ST_HUNT);

   always_comb begin
      state_next = state;
      legal      = (len_in != '0) && (32'(len_in) <= PAT_W);
      load_ok    = load && legal;
      cand       = {hist, din};
      pat_mask   = PAT_W'(mask(32'(len_r)));
      fill_ok    = (32'(fill) + 32'd1) >= 32'(len_r);
      hit        = 1'b0;
      if (load_ok) state_next = ST_HUNT;
      case (state)
         ST_HUNT: hit = din_valid && !load && fill_ok &&
                        (((cand ^ pat_r) & pat_mask) == '0);
         default: hit = 1'b0;
      endcase
      // Reset suppresses the Mealy output in the very cycle it is asserted.
      y = hit && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_UNLOADED;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_r    <= '0;
         len_r    <= '0;
         hist     <= '0;
         fill     <= '0;
         y_q      <= 1'b0;
         load_err <= 1'b0;
      end else begin
         y_q      <= y;
         load_err <= load && !legal;
         if (load_ok) begin
            pat_r <= pat_in;
            len_r <= len_in;
            hist  <= '0;
            fill  <= '0;
         end else if (!load && (state == ST_HUNT) && din_valid) begin
            if (hit && !overlap) begin
               hist <= '0;
               fill <= '0;
            end else begin
               hist <= cand[PAT_W-2:0];
               if (32'(fill) < (PAT_W - 1)) fill <= fill + LEN_W'(1);
            end
         end
      end
   end

   seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_cnt),
      .inc   (y),
      .cnt   (match_cnt)
   );

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench: expected y per driven cycle is queued, popped mid-cycle.
module tb_param_seq_detector;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       load = 1'b0;
   logic [7:0] pat_in = '0;
   logic [3:0] len_in = '0;
   logic       overlap = 1'b1;
   logic       clr_cnt = 1'b0;

   logic       y8, yq8, armed8, lerr8;
   logic [7:0] cnt8;
   logic       y2, yq2, armed2, lerr2;
   logic [1:0] cnt2;

   int n_chk  = 0;
   int n_fail = 0;
   logic sb[$];
   logic e;

   always #5 clk = ~clk;

   param_seq_detector #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .load(load),
      .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
      .y(y8), .y_q(yq8), .match_cnt(cnt8), .armed(armed8), .load_err(lerr8));

   param_seq_detector #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .load(load),
      .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
      .y(y2), .y_q(yq2), .match_cnt(cnt2), .armed(armed2), .load_err(lerr2));

   // Drives one cycle just after the edge and queues the expected y.
   task automatic drive(input logic l, input logic d, input logic v, input logic exp_y);
      @(posedge clk); #1;
      load = l; din = d; din_valid = v;
      sb.push_back(exp_y);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; load = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_chk++;
      if ({y8, yq8, cnt8, armed8, lerr8} !== 12'h0) begin
         n_fail++; $display("FAIL reset_dut8: got %h expected 000", {y8, yq8, cnt8, armed8, lerr8});
      end
      n_chk++;
      if ({y2, yq2, cnt2, armed2, lerr2} !== 6'h0) begin
         n_fail++; $display("FAIL reset_dut2: got %h expected 00", {y2, yq2, cnt2, armed2, lerr2});
      end
   endtask

   // Stream 1,0,1,1,0,1,1 against 1011.
   task automatic test_overlap_mode(input logic ov, input logic [6:0] exp_y, input int exp_cnt);
      logic [6:0] s;
      s = 7'b1011011;
      do_reset();
      overlap = ov; pat_in = 8'b0000_1011; len_in = 4'd4;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (y8 !== e) begin n_fail++; $display("FAIL ov%0d_load_y: got %b expected %b", ov, y8, e); end
      for (int i = 6; i >= 0; i--) begin
         drive(1'b0, s[i], 1'b1, exp_y[i]);
         @(negedge clk); e = sb.pop_front(); n_chk++;
         if (y8 !== e) begin
            n_fail++; $display("FAIL ov%0d_y_bit%0d: got %b expected %b", ov, 7 - i, y8, e);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (y8 !== e) begin n_fail++; $display("FAIL ov%0d_idle_y: got %b expected %b", ov, y8, e); end
      n_chk++;
      if (int'(cnt8) != exp_cnt || armed8 !== 1'b1) begin
         n_fail++; $display("FAIL ov%0d_cnt_armed: got %0d/%b expected %0d/1", ov, cnt8, armed8, exp_cnt);
      end
   endtask

   task automatic test_load_err();
      do_reset();
      overlap = 1'b1; pat_in = 8'b0000_1011;
      for (int k = 0; k < 2; k++) begin
         len_in = (k == 0) ? 4'd0 : 4'd9;
         drive(1'b1, 1'b1, 1'b1, 1'b0);
         @(negedge clk); e = sb.pop_front(); n_chk++;
         if (y8 !== e) begin n_fail++; $display("FAIL lerr_load_y%0d: got %b expected %b", k, y8, e); end
         drive(1'b0, 1'b1, 1'b1, 1'b0);
         @(negedge clk); e = sb.pop_front(); n_chk++;
         if (y8 !== e || lerr8 !== 1'b1 || armed8 !== 1'b0) begin
            n_fail++; $display("FAIL lerr_pulse%0d: got y=%b err=%b armed=%b expected y=%b err=1 armed=0", k, y8, lerr8, armed8, e);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (lerr8 !== 1'b0 || y8 !== e) begin
         n_fail++; $display("FAIL lerr_clear: got err=%b y=%b expected err=0 y=0", lerr8, y8);
      end
      // Illegal load while hunting must leave pattern and history intact.
      len_in = 4'd4;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      len_in = 4'd0;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk); n_chk++;
      if (lerr8 !== 1'b1 || armed8 !== 1'b1) begin
         n_fail++; $display("FAIL lerr_hunt: got err=%b armed=%b expected err=1 armed=1", lerr8, armed8);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      while (sb.size() > 1) void'(sb.pop_front());
      e = sb.pop_front(); n_chk++;
      if (y8 !== e) begin n_fail++; $display("FAIL lerr_hunt_match: got %b expected %b", y8, e); end
   endtask

   task automatic test_stall();
      logic [6:0] d, v, ey;
      do_reset();
      overlap = 1'b1; pat_in = 8'b0000_1011; len_in = 4'd4;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk); void'(sb.pop_front());
      d  = 7'b1011111;
      v  = 7'b1100011;
      ey = 7'b0000001;
      for (int i = 6; i >= 0; i--) begin
         drive(1'b0, d[i], v[i], ey[i]);
         @(negedge clk); e = sb.pop_front(); n_chk++;
         if (y8 !== e) begin n_fail++; $display("FAIL stall_y_step%0d: got %b expected %b", 6 - i, y8, e); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (yq8 !== 1'b1 || y8 !== e || cnt8 !== 8'd1) begin
         n_fail++; $display("FAIL stall_yq: got yq=%b y=%b cnt=%0d expected yq=1 y=0 cnt=1", yq8, y8, cnt8);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] ec;
      do_reset();
      overlap = 1'b1; pat_in = 8'h01; len_in = 4'd1;
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk); void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1);
         @(negedge clk); e = sb.pop_front();
         ec = (i < 3) ? 2'(i) : 2'd3;
         n_chk++;
         if (y8 !== e || y2 !== e || cnt2 !== ec) begin
            n_fail++; $display("FAIL sat_step%0d: got y=%b/%b cnt=%0d expected y=%b cnt=%0d", i, y8, y2, cnt2, e, ec);
         end
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (y2 !== e || cnt2 !== 2'd3 || cnt8 !== 8'd6) begin
         n_fail++; $display("FAIL sat_hold: got y=%b cnt2=%0d cnt8=%0d expected y=0 cnt2=3 cnt8=6", y2, cnt2, cnt8);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      clr_cnt = 1'b1;
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (y2 !== e) begin n_fail++; $display("FAIL clr_y: got %b expected %b", y2, e); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      clr_cnt = 1'b0;
      @(negedge clk); void'(sb.pop_front()); n_chk++;
      if (cnt2 !== 2'd0 || cnt8 !== 8'd0) begin
         n_fail++; $display("FAIL clr_wins: got cnt2=%0d cnt8=%0d expected 0/0", cnt2, cnt8);
      end
   endtask

   task automatic test_reload_reset();
      logic [3:0] s;
      logic [2:0] s2, ey;
      do_reset();
      overlap = 1'b1; pat_in = 8'b0000_1011; len_in = 4'd4;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      s = 4'b1010;
      for (int i = 3; i >= 0; i--) drive(1'b0, s[i], 1'b1, 1'b0);
      pat_in = 8'b0000_0001; len_in = 4'd2;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      while (sb.size() > 1) void'(sb.pop_front());
      e = sb.pop_front(); n_chk++;
      if (y8 !== e) begin n_fail++; $display("FAIL reload_load_y: got %b expected %b", y8, e); end
      s2 = 3'b101;
      ey = 3'b001;
      for (int i = 2; i >= 0; i--) begin
         drive(1'b0, s2[i], 1'b1, ey[i]);
         @(negedge clk); e = sb.pop_front(); n_chk++;
         if (y8 !== e) begin n_fail++; $display("FAIL reload_y_step%0d: got %b expected %b", 2 - i, y8, e); end
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); void'(sb.pop_front());
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (y8 !== e) begin n_fail++; $display("FAIL reset_cycle_y: got %b expected %b", y8, e); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk); void'(sb.pop_front()); n_chk++;
      if ({y8, yq8, cnt8, armed8, lerr8} !== 12'h0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h expected 000", {y8, yq8, cnt8, armed8, lerr8});
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (y8 !== e || armed8 !== 1'b0) begin
         n_fail++; $display("FAIL unloaded_y: got y=%b armed=%b expected y=0 armed=0", y8, armed8);
      end
   endtask

   initial begin
      test_reset();
      test_overlap_mode(1'b1, 7'b0001001, 2);
      test_overlap_mode(1'b0, 7'b0001000, 1);
      test_load_err();
      test_stall();
      test_saturate();
      test_reload_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
